// File: rtl/dap_swj_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// dap_swj_seq_ctrl_if
// Bundle of all non-clock/non-reset signals of the SWJ sequence splitter.
//   req_valid / req_ready / req_bits   : sequence request from the command decoder
//   word_valid / word_ready / word_data: 64-bit sequence data words, LSB first
//   abort                              : level request to stop after the current chunk
//   eng_tx_valid / eng_tx_cmd / eng_tx_data / eng_done : SWJ sequence engine link
//   busy / done / status               : controller progress and completion report
// Modports:
//   slave  - the controller (dap_swj_seq_ctrl)
//   master - the environment driving requests, words, abort and engine completion
// ---------------------------------------------------------------------------
interface dap_swj_seq_ctrl_if ();
   logic        req_valid;
   logic        req_ready;
   logic [8:0]  req_bits;
   logic        word_valid;
   logic        word_ready;
   logic [63:0] word_data;
   logic        abort;
   logic        eng_tx_valid;
   logic [15:0] eng_tx_cmd;
   logic [63:0] eng_tx_data;
   logic        eng_done;
   logic        busy;
   logic        done;
   logic [1:0]  status;

   modport slave (
      input  req_valid, req_bits, word_valid, word_data, abort, eng_done,
      output req_ready, word_ready, eng_tx_valid, eng_tx_cmd, eng_tx_data,
             busy, done, status
   );

   modport master (
      output req_valid, req_bits, word_valid, word_data, abort, eng_done,
      input  req_ready, word_ready, eng_tx_valid, eng_tx_cmd, eng_tx_data,
             busy, done, status
   );
endinterface

// File: rtl/dap_swj_seq_ctrl.sv
// ---------------------------------------------------------------------------
// dap_swj_seq_ctrl
// Splits an SWJ_Sequence request of up to 256 bits into chunks of at most 64
// bits, hands each chunk to the SWJ sequence engine and waits for the engine's
// completion edge before fetching the next word. Reports OK / ABORT / TIMEOUT.
// Ports:
//   sclk    in  clock
//   resetn  in  asynchronous active-low reset
//   bus     slave modport of dap_swj_seq_ctrl_if (request, word stream,
//           abort, engine link, busy/done/status)
// Parameters:
//   SWJ_CMD      opcode placed in eng_tx_cmd[15:12]
//   MIN_GAP      minimum cycles eng_tx_valid stays low between chunks (>=2)
//   TIMEOUT_CYC  WAIT cycles allowed without an engine completion edge
// ---------------------------------------------------------------------------
module dap_swj_seq_ctrl #(
   parameter logic [3:0] SWJ_CMD     = 4'h1,
   parameter int         MIN_GAP     = 2,
   parameter int         TIMEOUT_CYC = 1024
) (
   input  logic              sclk,
   input  logic              resetn,
   dap_swj_seq_ctrl_if.slave bus
);

   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam int GW = $clog2(MIN_GAP);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(MIN_GAP - 1);

   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_ABORT   = 2'd1;
   localparam logic [1:0] ST_TIMEOUT = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_GAP,
      S_DRAIN,
      S_FINISH
   } state_t;

   state_t        state_reg;
   logic [8:0]    rem_reg;
   logic [2:0]    words_left_reg;
   logic [TW-1:0] to_cnt_reg;
   logic [GW-1:0] gap_cnt_reg;
   logic          abort_seen_reg;
   logic          eng_done_q_reg;

   logic          req_ready_reg;
   logic          word_ready_reg;
   logic          eng_tx_valid_reg;
   logic [15:0]   eng_tx_cmd_reg;
   logic [63:0]   eng_tx_data_reg;
   logic          busy_reg;
   logic          done_reg;
   logic [1:0]    status_reg;

   logic [8:0]    req_len;
   logic [2:0]    req_words;
   logic [8:0]    chunk;
   logic          done_edge;
   logic          word_hs;
   logic          abort_any;

   // A request field of 0 encodes the maximum length of 256 bits.
   assign req_len   = (bus.req_bits == 9'd0) ? 9'd256 : bus.req_bits;
   assign req_words = 3'(({1'b0, req_len} + 10'd63) >> 6);
   assign chunk     = (rem_reg > 9'd64) ? 9'd64 : rem_reg;
   // The engine may hold eng_done for several cycles; only its rising edge counts.
   assign done_edge = bus.eng_done & ~eng_done_q_reg;
   assign word_hs   = bus.word_valid & word_ready_reg;
   // Abort is a level; remember it so a pulse during FETCH/ISSUE/WAIT is not lost.
   assign abort_any = abort_seen_reg | bus.abort;

   always_ff @(posedge sclk or negedge resetn) begin
      if (!resetn) begin
         state_reg        <= S_IDLE;
         rem_reg          <= '0;
         words_left_reg   <= '0;
         to_cnt_reg       <= '0;
         gap_cnt_reg      <= '0;
         abort_seen_reg   <= 1'b0;
         eng_done_q_reg   <= 1'b0;
         req_ready_reg    <= 1'b1;
         word_ready_reg   <= 1'b0;
         eng_tx_valid_reg <= 1'b0;
         eng_tx_cmd_reg   <= '0;
         eng_tx_data_reg  <= '0;
         busy_reg         <= 1'b0;
         done_reg         <= 1'b0;
         status_reg       <= ST_OK;
      end else begin
         eng_done_q_reg <= bus.eng_done;
         done_reg       <= 1'b0;
         if (state_reg != S_IDLE && bus.abort) begin
            abort_seen_reg <= 1'b1;
         end

         case (state_reg)
            S_IDLE: begin
               if (bus.req_valid) begin
                  rem_reg        <= req_len;
                  words_left_reg <= req_words;
                  abort_seen_reg <= 1'b0;
                  status_reg     <= ST_OK;
                  req_ready_reg  <= 1'b0;
                  busy_reg       <= 1'b1;
                  word_ready_reg <= 1'b1;
                  state_reg      <= S_FETCH;
               end
            end

            S_FETCH: begin
               if (word_hs) begin
                  eng_tx_data_reg <= bus.word_data;
                  eng_tx_cmd_reg  <= {SWJ_CMD, 4'h0, chunk[7:0]};
                  rem_reg         <= rem_reg - chunk;
                  words_left_reg  <= words_left_reg - 3'd1;
                  word_ready_reg  <= 1'b0;
                  state_reg       <= S_ISSUE;
               end
            end

            S_ISSUE: begin
               eng_tx_valid_reg <= 1'b1;
               to_cnt_reg       <= '0;
               state_reg        <= S_WAIT;
            end

            S_WAIT: begin
               if (done_edge) begin
                  eng_tx_valid_reg <= 1'b0;
                  gap_cnt_reg      <= '0;
                  state_reg        <= S_GAP;
               end else if (to_cnt_reg == TO_LAST) begin
                  // Timeout wins over any abort already latched in this run.
                  eng_tx_valid_reg <= 1'b0;
                  status_reg       <= ST_TIMEOUT;
                  if (words_left_reg == 3'd0) begin
                     done_reg  <= 1'b1;
                     state_reg <= S_FINISH;
                  end else begin
                     word_ready_reg <= 1'b1;
                     state_reg      <= S_DRAIN;
                  end
               end else begin
                  to_cnt_reg <= to_cnt_reg + TW'(1);
               end
            end

            S_GAP: begin
               if (gap_cnt_reg != GAP_LAST) begin
                  gap_cnt_reg <= gap_cnt_reg + GW'(1);
               end else if (abort_any) begin
                  status_reg <= ST_ABORT;
                  if (words_left_reg == 3'd0) begin
                     done_reg  <= 1'b1;
                     state_reg <= S_FINISH;
                  end else begin
                     word_ready_reg <= 1'b1;
                     state_reg      <= S_DRAIN;
                  end
               end else if (rem_reg == 9'd0) begin
                  status_reg <= ST_OK;
                  done_reg   <= 1'b1;
                  state_reg  <= S_FINISH;
               end else begin
                  word_ready_reg <= 1'b1;
                  state_reg      <= S_FETCH;
               end
            end

            S_DRAIN: begin
               // Remaining words are consumed so the decoder's stream stays aligned.
               if (word_hs) begin
                  words_left_reg <= words_left_reg - 3'd1;
                  if (words_left_reg == 3'd1) begin
                     word_ready_reg <= 1'b0;
                     done_reg       <= 1'b1;
                     state_reg      <= S_FINISH;
                  end
               end
            end

            S_FINISH: begin
               busy_reg      <= 1'b0;
               req_ready_reg <= 1'b1;
               state_reg     <= S_IDLE;
            end

            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready    = req_ready_reg;
   assign bus.word_ready   = word_ready_reg;
   assign bus.eng_tx_valid = eng_tx_valid_reg;
   assign bus.eng_tx_cmd   = eng_tx_cmd_reg;
   assign bus.eng_tx_data  = eng_tx_data_reg;
   assign bus.busy         = busy_reg;
   assign bus.done         = done_reg;
   assign bus.status       = status_reg;

endmodule

// File: tb/tb_dap_swj_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dap_swj_seq_ctrl
// Self-checking bench for dap_swj_seq_ctrl. Directed cases followed by
// randomized requests; expected chunk commands, data, word consumption and
// final status come from a length/abort/timeout rule model of the request.
// ---------------------------------------------------------------------------
module tb_dap_swj_seq_ctrl;

   logic sclk   = 1'b0;
   logic resetn = 1'b0;
   int   errors = 0;
   int   checks = 0;

   dap_swj_seq_ctrl_if bus ();

   dap_swj_seq_ctrl #(
      .SWJ_CMD    (4'h1),
      .MIN_GAP    (2),
      .TIMEOUT_CYC(1024)
   ) dut (
      .sclk  (sclk),
      .resetn(resetn),
      .bus   (bus)
   );

   always #5 sclk = ~sclk;

   // Scenario description
   int          n_bits;
   logic [8:0]  req_field;
   logic [63:0] words [4];
   int          abort_chunk;   // 0: never; else abort raised when chunk N starts
   int          hang_chunk;    // 0: never; else engine ignores chunk N
   int          eng_delay;
   int          eng_hold;
   bit          reset_in_wait;

   // Observations
   logic [15:0] got_cmd [$];
   logic [63:0] got_data [$];
   int          words_taken;
   logic [1:0]  got_status;
   bit          got_done;
   int          last_rise_len;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_tx_valid"}, 64'(bus.eng_tx_valid), 64'd0);
      check({tag, "_tx_cmd"},   64'(bus.eng_tx_cmd),   64'd0);
      check({tag, "_tx_data"},  bus.eng_tx_data,       64'd0);
      check({tag, "_done"},     64'(bus.done),         64'd0);
      check({tag, "_status"},   64'(bus.status),       64'd0);
      check({tag, "_busy"},     64'(bus.busy),         64'd0);
      check({tag, "_wready"},   64'(bus.word_ready),   64'd0);
      check({tag, "_rready"},   64'(bus.req_ready),    64'd1);
   endtask

   task automatic set_req(input int n, input logic [8:0] field, input int ab, input int hg);
      n_bits        = n;
      req_field     = field;
      abort_chunk   = ab;
      hang_chunk    = hg;
      eng_delay     = int'($urandom_range(5, 1));
      eng_hold      = int'($urandom_range(3, 1));
      reset_in_wait = 1'b0;
      for (int i = 0; i < 4; i++) words[i] = {$urandom, $urandom};
   endtask

   task automatic cleanup();
      bus.req_valid  = 1'b0;
      bus.word_valid = 1'b0;
      bus.abort      = 1'b0;
      bus.eng_done   = 1'b0;
   endtask

   // Drives one request cycle by cycle, acting as word source and engine.
   task automatic run_req(input string tag);
      int edge_n    = 0;
      int k         = (n_bits + 63) / 64;
      int hs_edge   = -100;
      int fall_edge = -100;
      int rise_edge = -100;
      int eng_start = -1;
      int busy_bad  = 0;
      bit prev_valid = 1'b0;
      bit prev_wv;
      bit prev_wr;
      bit finished  = 1'b0;

      got_cmd.delete();
      got_data.delete();
      words_taken   = 0;
      got_done      = 1'b0;
      got_status    = 2'bxx;
      last_rise_len = -1;

      check({tag, "_idle_rready"}, 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b1;
      bus.req_bits  = req_field;

      while (!finished && edge_n < 4000) begin
         prev_wv = bus.word_valid;
         prev_wr = bus.word_ready;
         @(posedge sclk);
         #1;
         edge_n++;
         bus.req_valid = 1'b0;

         if (prev_wv && prev_wr) begin
            words_taken++;
            hs_edge = edge_n;
         end

         if (bus.eng_tx_valid && !prev_valid) begin
            rise_edge = edge_n;
            got_cmd.push_back(bus.eng_tx_cmd);
            got_data.push_back(bus.eng_tx_data);
            // Handshake in cycle T -> valid high from T+2: one edge after the handshake edge.
            check({tag, "_latency"}, 64'(edge_n - hs_edge), 64'd1);
            if (got_cmd.size() > 1)
               check({tag, "_gap_ge2"}, 64'(edge_n - fall_edge >= 2), 64'd1);
            if (reset_in_wait) begin
               repeat (2) @(posedge sclk);
               #1;
               check({tag, "_in_wait"}, 64'(bus.eng_tx_valid), 64'd1);
               resetn = 1'b0;
               #1;
               cleanup();
               return;
            end
            if (got_cmd.size() == abort_chunk) bus.abort = 1'b1;
            eng_start = (got_cmd.size() == hang_chunk) ? -1 : edge_n + eng_delay;
         end
         if (!bus.eng_tx_valid && prev_valid) begin
            fall_edge     = edge_n;
            last_rise_len = edge_n - rise_edge;
         end
         prev_valid = bus.eng_tx_valid;

         if (!bus.busy || bus.req_ready) busy_bad++;
         if (bus.done) begin
            finished   = 1'b1;
            got_done   = 1'b1;
            got_status = bus.status;
         end

         bus.eng_done   = (eng_start >= 0) && (edge_n >= eng_start) && (edge_n < eng_start + eng_hold);
         bus.word_valid = (words_taken < k) && ($urandom_range(3, 0) != 0);
         bus.word_data  = (words_taken < k) ? words[words_taken] : {$urandom, $urandom};
      end

      check({tag, "_bounded"}, 64'(finished), 64'd1);
      check({tag, "_busy"}, 64'(busy_bad), 64'd0);
      cleanup();
      @(posedge sclk);
      #1;
      check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
      check({tag, "_idle_busy"},  64'(bus.busy), 64'd0);
      check({tag, "_idle_rdy"},   64'(bus.req_ready), 64'd1);
   endtask

   // Reference rules: chunks of min(64, remaining); a hang on chunk H times out
   // there unless an earlier abort ended the run; an abort raised during chunk A
   // stops after A; every word of the request is consumed either way.
   task automatic check_result(input string tag);
      int         k         = (n_bits + 63) / 64;
      int         end_chunk = k;
      logic [1:0] exp_st    = 2'd0;
      int         nchk;
      int         bits;
      if (hang_chunk != 0 && (abort_chunk == 0 || hang_chunk <= abort_chunk)) begin
         end_chunk = hang_chunk;
         exp_st    = 2'd2;
      end else if (abort_chunk != 0) begin
         end_chunk = abort_chunk;
         exp_st    = 2'd1;
      end
      check({tag, "_done"},   64'(got_done), 64'd1);
      check({tag, "_status"}, 64'(got_status), 64'(exp_st));
      check({tag, "_chunks"}, 64'(got_cmd.size()), 64'(end_chunk));
      check({tag, "_words"},  64'(words_taken), 64'(k));
      nchk = (got_cmd.size() < end_chunk) ? got_cmd.size() : end_chunk;
      for (int i = 0; i < nchk; i++) begin
         bits = n_bits - 64 * i;
         if (bits > 64) bits = 64;
         check({tag, "_cmd"},  64'(got_cmd[i]), 64'(16'h1000 + 16'(bits)));
         check({tag, "_data"}, got_data[i], words[i]);
      end
      if (exp_st == 2'd2)
         check({tag, "_to_len"}, 64'(last_rise_len), 64'd1024);
      $display("req bits=%0d chunks=%0d words=%0d status=%0d abort@%0d hang@%0d",
               n_bits, got_cmd.size(), words_taken, got_status, abort_chunk, hang_chunk);
   endtask

   initial begin
      int n;
      int k;
      int ab;
      int hg;
      logic [8:0] field;

      bus.req_valid  = 1'b0;
      bus.req_bits   = 9'd0;
      bus.word_valid = 1'b0;
      bus.word_data  = 64'd0;
      bus.abort      = 1'b0;
      bus.eng_done   = 1'b0;
      resetn         = 1'b0;
      repeat (3) @(posedge sclk);
      #1;
      check_reset("rst");
      resetn = 1'b1;
      @(posedge sclk);
      #1;

      // 51 bits, single word 0x5A -> cmd 0x1033
      set_req(51, 9'd51, 0, 0);
      words[0] = 64'h5A;
      run_req("b51");
      check_result("b51");

      // field 0 means 256 bits: four full chunks
      set_req(256, 9'd0, 0, 0);
      run_req("b256");
      check_result("b256");

      // 100 bits -> 0x1040 then 0x1024
      set_req(100, 9'd100, 0, 0);
      run_req("b100");
      check_result("b100");

      // abort during chunk 1 of 256 -> one chunk, three words drained
      set_req(256, 9'd256, 1, 0);
      run_req("abort");
      check_result("abort");

      // engine silent on chunk 1 -> timeout after 1024 WAIT cycles
      set_req(200, 9'd200, 0, 1);
      run_req("tmo");
      check_result("tmo");

      // abort and timeout in the same chunk: timeout wins
      set_req(128, 9'd128, 2, 2);
      run_req("tmo_ab");
      check_result("tmo_ab");

      // reset while waiting on the engine, then a fresh 8-bit request
      set_req(256, 9'd0, 0, 0);
      reset_in_wait = 1'b1;
      run_req("rstw");
      check_reset("rst_wait");
      @(posedge sclk);
      #1;
      resetn = 1'b1;
      @(posedge sclk);
      #1;
      set_req(8, 9'd8, 0, 0);
      run_req("b8");
      check_result("b8");

      // randomized requests
      for (int r = 0; r < 24; r++) begin
         n     = int'($urandom_range(256, 1));
         k     = (n + 63) / 64;
         field = 9'(n);
         if (n == 256 && $urandom_range(1, 0) == 1) field = 9'd0;
         ab = ($urandom_range(3, 0) == 0) ? int'($urandom_range(k, 1)) : 0;
         hg = ($urandom_range(7, 0) == 0) ? int'($urandom_range(k, 1)) : 0;
         set_req(n, field, ab, hg);
         run_req("rnd");
         check_result("rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
